// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX issue stage ahead of the ALU.
// Captures decoded operands into a two-entry (main + skid) buffer with
// valid/ready handshakes on both sides, flags unimplemented operation codes
// and counts downstream stall cycles.
// Optional feature macro: ALU_FWD_EN (operand forwarding at capture).
module alu_issue_stage #(
   parameter int unsigned WORDSIZE = 64,
   parameter int unsigned REGADDR  = 5,
   parameter int unsigned CNTWIDTH = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WORDSIZE-1:0] in_rs1_data,
   input  logic [WORDSIZE-1:0] in_rs2_data,
   input  logic [WORDSIZE-1:0] in_imm,
   input  logic                in_use_imm,
   input  logic [REGADDR-1:0]  in_rs1_addr,
   input  logic [REGADDR-1:0]  in_rs2_addr,
   input  logic [REGADDR-1:0]  in_rd_addr,
   input  logic [5:0]          in_operation,
   input  logic                fwd_valid,
   input  logic [REGADDR-1:0]  fwd_rd_addr,
   input  logic [WORDSIZE-1:0] fwd_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WORDSIZE-1:0] input_a,
   output logic [WORDSIZE-1:0] input_b,
   output logic [5:0]          operation,
   output logic [REGADDR-1:0]  out_rd_addr,
   output logic                op_illegal,
   output logic [CNTWIDTH-1:0] stall_count
);

   localparam int unsigned OPW = 6;

   typedef struct packed {
      logic [WORDSIZE-1:0] a;
      logic [WORDSIZE-1:0] b;
      logic [OPW-1:0]      op;
      logic [REGADDR-1:0]  rd;
      logic                ill;
   } entry_t;

   typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

   state_t state, state_next;
   entry_t cap, main_q, skid_q;
   logic   accept, pop;
   logic   take_in, skid_load, skid_to_main;

   // Legal codes: 00_0000..00_0100, 01_0000..01_0010, 1x_0000..1x_0011
   function automatic logic op_is_illegal(input logic [OPW-1:0] op);
      logic ill;
      case (op[5:4])
         2'b00:   ill = (op[3:0] > 4'd4);
         2'b01:   ill = (op[3:0] > 4'd2);
         default: ill = (op[3:0] > 4'd3);
      endcase
      return ill;
   endfunction

`ifndef ALU_FWD_EN
   logic unused_fwd;
   assign unused_fwd = ^{fwd_valid, fwd_rd_addr, fwd_data, in_rs1_addr, in_rs2_addr};
`endif

   // Build the entry to be captured: operand B select, optional forwarding, legality
   always_comb begin
      cap.a   = in_rs1_data;
      cap.b   = in_use_imm ? in_imm : in_rs2_data;
      cap.op  = in_operation;
      cap.rd  = in_rd_addr;
      cap.ill = op_is_illegal(in_operation);
`ifdef ALU_FWD_EN
      if (fwd_valid && (fwd_rd_addr != '0)) begin
         if (fwd_rd_addr == in_rs1_addr) cap.a = fwd_data;
         if ((fwd_rd_addr == in_rs2_addr) && !in_use_imm) cap.b = fwd_data;
      end
`endif
   end

   assign accept = in_valid & in_ready;
   assign pop    = out_valid & out_ready;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= EMPTY;
      else     state <= state_next;
   end

   // Next-state and buffer steering
   always_comb begin
      state_next   = state;
      take_in      = 1'b0;
      skid_load    = 1'b0;
      skid_to_main = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: if (accept) begin
               state_next = BUSY;
               take_in    = 1'b1;
            end
            BUSY: begin
               if (accept && !pop) begin
                  state_next = FULL;
                  skid_load  = 1'b1;
               end else if (!accept && pop) begin
                  state_next = EMPTY;
               end else if (accept && pop) begin
                  take_in = 1'b1;
               end
            end
            FULL: if (pop) begin
               state_next   = BUSY;
               skid_to_main = 1'b1;
            end
            default: state_next = EMPTY;
         endcase
      end
   end

   // Entry storage, handshake flags and saturating stall counter
   always_ff @(posedge clk) begin
      if (rst) begin
         main_q      <= '0;
         skid_q      <= '0;
         out_valid   <= 1'b0;
         in_ready    <= 1'b1;
         stall_count <= '0;
      end else begin
         out_valid <= (state_next != EMPTY);
         in_ready  <= (state_next != FULL);
         if (take_in)           main_q <= cap;
         else if (skid_to_main) main_q <= skid_q;
         if (skid_load) skid_q <= cap;
         if (out_valid && !out_ready && (stall_count != '1))
            stall_count <= stall_count + CNTWIDTH'(1);
      end
   end

   assign input_a     = main_q.a;
   assign input_b     = main_q.b;
   assign operation   = main_q.op;
   assign out_rd_addr = main_q.rd;
   assign op_illegal  = main_q.ill;

endmodule
